// File: rtl/led_pkg.sv
// Shared encodings for the LED driver: command codes, mode encoding and a counter-width helper.
package led_pkg;

    localparam logic [1:0] CMD_OFF    = 2'b00;
    localparam logic [1:0] CMD_ON     = 2'b01;
    localparam logic [1:0] CMD_TOGGLE = 2'b10;
    localparam logic [1:0] CMD_BLINK  = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_BLINK = 2'b10,
        ST_FADE  = 2'b11
    } led_state_e;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_driver_if.sv
// Command channel into the LED driver: valid/ready handshake carrying a command code and a brightness.
interface led_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd;
    logic [PWM_BITS-1:0] duty;

    modport master (output cmd_valid, output cmd, output duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, input duty, output cmd_ready);
endinterface

// File: rtl/led_pwm.sv
// Free-running PWM counter with brightness compare; all-ones duty gives a gap-free lit output.
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_eff,
    output logic                lit_pwm
);

    localparam logic [PWM_BITS-1:0] FULL = '1;

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // A plain compare would leave one dark count per period at full brightness.
    assign lit_pwm = (duty_eff == FULL) || (pwm_cnt < duty_eff);

endmodule

// File: rtl/led_driver.sv
// Command-driven active-low LED driver with PWM brightness and blinking.
// Optional soft turn-on ramp enabled by defining LED_FADE_EN.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_OFF   | LED dark (pin high)
//  ST_ON    | LED driven at duty_reg brightness
//  ST_BLINK | alternates lit/dark every BLINK_HALF_CYCLES, lit at duty_reg
//  ST_FADE  | brightness ramps from 0 up to duty_reg, commands held off
module led_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS          = 8,
    parameter int BLINK_HALF_CYCLES = 12_500_000,
    parameter int FADE_STEP_CYCLES  = 195_312
) (
    input  logic              clk,
    input  logic              rst,
    led_driver_if.slave       cmd_if,
    output logic              led,
    output logic [1:0]        state_o
);

    localparam int BW = cnt_width(BLINK_HALF_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

    if (BLINK_HALF_CYCLES < 2 || FADE_STEP_CYCLES < 1) begin : g_param_check
        $error("led_driver: BLINK_HALF_CYCLES must be >= 2 and FADE_STEP_CYCLES >= 1");
    end

    led_state_e          state_q, state_d;
    led_state_e          on_entry;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_eff;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_dark_q, blink_dark_d;
    logic                blink_restart;
    logic                accept;
    logic                lit_pwm;
    logic                led_d;

    assign accept = cmd_if.cmd_valid && cmd_if.cmd_ready;

`ifdef LED_FADE_EN
    localparam int FW = cnt_width(FADE_STEP_CYCLES);
    localparam logic [FW-1:0] FADE_LAST = FW'(FADE_STEP_CYCLES - 1);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [FW-1:0]       fade_cnt_q, fade_cnt_d;

    assign cmd_if.cmd_ready = (state_q != ST_FADE);
    // Only a turn-on from dark ramps; a zero target has nothing to ramp to.
    assign on_entry = (state_q == ST_OFF && cmd_if.duty != '0) ? ST_FADE : ST_ON;
`else
    assign cmd_if.cmd_ready = 1'b1;
    assign on_entry = ST_ON;
`endif

    always_comb begin
        state_d       = state_q;
        duty_d        = duty_q;
        blink_restart = 1'b0;
        if (accept) begin
            case (cmd_if.cmd)
                CMD_OFF: begin
                    state_d = ST_OFF;
                end
                CMD_ON: begin
                    duty_d  = cmd_if.duty;
                    state_d = on_entry;
                end
                CMD_TOGGLE: begin
                    if (state_q == ST_OFF) begin
                        duty_d  = cmd_if.duty;
                        state_d = on_entry;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                CMD_BLINK: begin
                    duty_d        = cmd_if.duty;
                    state_d       = ST_BLINK;
                    blink_restart = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
`ifdef LED_FADE_EN
        else if (state_q == ST_FADE && level_q == duty_q) begin
            state_d = ST_ON;
        end
`endif
    end

    // Blink phase: every (re)entry starts a fresh lit half-period.
    always_comb begin
        blink_cnt_d  = '0;
        blink_dark_d = 1'b0;
        if (state_d == ST_BLINK && !blink_restart) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d  = '0;
                blink_dark_d = !blink_dark_q;
            end else begin
                blink_cnt_d  = blink_cnt_q + BW'(1);
                blink_dark_d = blink_dark_q;
            end
        end
    end

`ifdef LED_FADE_EN
    always_comb begin
        level_d    = '0;
        fade_cnt_d = '0;
        if (state_q == ST_FADE && state_d == ST_FADE) begin
            if (fade_cnt_q == FADE_LAST) begin
                fade_cnt_d = '0;
                level_d    = level_q + PWM_BITS'(1);
            end else begin
                fade_cnt_d = fade_cnt_q + FW'(1);
                level_d    = level_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= '0;
            fade_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            fade_cnt_q <= fade_cnt_d;
        end
    end

    assign duty_eff = (state_d == ST_FADE) ? level_d : duty_d;
`else
    assign duty_eff = duty_d;
`endif

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_eff (duty_eff),
        .lit_pwm  (lit_pwm)
    );

    // The pin is computed from the next mode so it changes on the same edge as state_o.
    assign led_d = (state_d == ST_OFF) || (state_d == ST_BLINK && blink_dark_d) || !lit_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            duty_q       <= '0;
            blink_cnt_q  <= '0;
            blink_dark_q <= 1'b0;
            led          <= 1'b1;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_dark_q <= blink_dark_d;
            led          <= led_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: directed scenarios plus random commands against a cycle-age model.
module tb_led_driver;

    localparam int PB   = 3;
    localparam int HALF = 4;
    localparam int STEP = 2;
    localparam int FULL = (1 << PB) - 1;

    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_BLINK = 2;
    localparam int M_FADE  = 3;

`ifdef LED_FADE_EN
    localparam bit FADE_BUILD = 1'b1;
`else
    localparam bit FADE_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       led;
    logic [1:0] state_o;

    led_driver_if #(.PWM_BITS(PB)) cmd_if ();

    led_driver #(
        .PWM_BITS          (PB),
        .BLINK_HALF_CYCLES (HALF),
        .FADE_STEP_CYCLES  (STEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (cmd_if),
        .led     (led),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: mode plus "cycles since entry" ages and the PWM position
    int m_mode, m_duty, m_blink_age, m_fade_age, m_pwm;
    bit m_led;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic turn_on(input int d);
        m_duty = d;
        if (m_mode == M_OFF && FADE_BUILD && d != 0) begin
            m_mode     = M_FADE;
            m_fade_age = 0;
        end else begin
            m_mode = M_ON;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit [1:0] c, input int d);
        int p, de;
        bit lit;
        if (r) begin
            m_mode = M_OFF; m_duty = 0; m_blink_age = 0; m_fade_age = 0; m_pwm = 0; m_led = 1'b1;
            return;
        end
        if (v && m_mode != M_FADE) begin
            case (c)
                2'b00: m_mode = M_OFF;
                2'b01: turn_on(d);
                2'b10: if (m_mode == M_OFF) turn_on(d); else m_mode = M_OFF;
                default: begin m_duty = d; m_mode = M_BLINK; m_blink_age = 0; end
            endcase
        end else if (m_mode == M_BLINK) begin
            m_blink_age++;
        end else if (m_mode == M_FADE) begin
            if (m_fade_age / STEP == m_duty) m_mode = M_ON;
            else m_fade_age++;
        end
        p     = m_pwm;
        m_pwm = (m_pwm + 1) % (FULL + 1);
        de    = (m_mode == M_FADE) ? m_fade_age / STEP : m_duty;
        lit   = (de == FULL) || (p < de);
        if (m_mode == M_OFF) m_led = 1'b1;
        else if (m_mode == M_BLINK && ((m_blink_age / HALF) % 2) == 1) m_led = 1'b1;
        else m_led = !lit;
    endtask

    task automatic step(input bit r, input bit v, input bit [1:0] c, input int d);
        @(negedge clk);
        rst              = r;
        cmd_if.cmd_valid = v;
        cmd_if.cmd       = c;
        cmd_if.duty      = PB'(d);
        @(posedge clk);
        model_edge(r, v, c, d & FULL);
        #1;
        check("state_o", 32'(state_o), 32'(m_mode));
        check("led", 32'(led), 32'(m_led));
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(m_mode != M_FADE));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 0);
    endtask

    int lit_cnt;
    int busy_cnt;

    initial begin
        rst = 1'b1; cmd_if.cmd_valid = 1'b0; cmd_if.cmd = 2'b00; cmd_if.duty = '0;
        m_mode = M_OFF; m_duty = 0; m_blink_age = 0; m_fade_age = 0; m_pwm = 0; m_led = 1'b1;

        // reset, then reset again in the middle of a blink
        step(1'b1, 1'b0, 2'b00, 0);
        step(1'b1, 1'b0, 2'b00, 0);
        step(1'b0, 1'b1, 2'b11, 7);
        idle(6);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_led", 32'(led), 1);
        check("rst_ready", 32'(cmd_if.cmd_ready), 1);
        idle(2);

        // ON at 3/8 brightness, then full
        step(1'b0, 1'b1, 2'b01, 3);
        check("on_state", 32'(state_o), FADE_BUILD ? M_FADE : M_ON);
        idle(FADE_BUILD ? 10 : 2);
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (led == 1'b0) lit_cnt++;
        end
        check("duty3_lit", 32'(lit_cnt), 3);
        step(1'b0, 1'b1, 2'b01, 7);
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (led == 1'b0) lit_cnt++;
        end
        check("duty7_lit", 32'(lit_cnt), 8);

        // blink, then restart it from the dark phase
        step(1'b0, 1'b1, 2'b11, 7);
        idle(5);
        check("blink_dark", 32'(led), 1);
        step(1'b0, 1'b1, 2'b11, 7);
        check("blink_restart", 32'(led), 0);
        idle(10);

        // toggles
        step(1'b0, 1'b1, 2'b00, 0);
        step(1'b0, 1'b1, 2'b10, 5);
        idle(FADE_BUILD ? 13 : 2);
        step(1'b0, 1'b1, 2'b10, 2);
        idle(2);
        step(1'b0, 1'b1, 2'b11, 7);
        idle(2);
        step(1'b0, 1'b1, 2'b10, 7);
        check("toggle_blink_off", 32'(led), 1);
        idle(2);

        // zero duty, and OFF leaving the stored brightness alone
        step(1'b0, 1'b1, 2'b01, 0);
        check("duty0_state", 32'(state_o), M_ON);
        idle(10);
        step(1'b0, 1'b1, 2'b00, 5);
        step(1'b0, 1'b1, 2'b10, 0);
        check("toggle_duty0", 32'(state_o), M_ON);
        idle(9);

`ifdef LED_FADE_EN
        // ramp to 4 with commands thrown at it while busy
        step(1'b0, 1'b1, 2'b00, 0);
        step(1'b0, 1'b1, 2'b01, 4);
        busy_cnt = (cmd_if.cmd_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(0, FULL)));
            if (cmd_if.cmd_ready == 1'b0) busy_cnt++;
        end
        check("fade_busy_cycles", 32'(busy_cnt), 9);
        idle(4);
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), int'($urandom_range(0, FULL)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
